// File: rtl/lfsr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lfsr_pkg                                                             |
// | FSM state codes, default maximal tap masks and the LFSR step helper. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package lfsr_pkg;

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_WARM = 2'd1;
  localparam logic [1:0] c_ST_GEN  = 2'd2;

  // Trinomial x^n + x^k + 1 maps to taps on bits 0 and k; 0 means no entry.
  function automatic logic [31:0] default_taps(input int unsigned width);
    case (width)
      2, 3, 4, 6, 7, 15: default_taps = 32'h0000_0003;
      5, 11:             default_taps = 32'h0000_0005;
      9:                 default_taps = 32'h0000_0011;
      10, 17, 31:        default_taps = 32'h0000_0009;
      default:           default_taps = 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] st,
                                            input logic [31:0] taps,
                                            input int unsigned width);
    logic fb;
    fb = ^(st & taps);
    lfsr_next = (st >> 1) | (32'(fb) << (width - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_frame_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lfsr_frame_gen_if                                                    |
// | Control, seed and serial valid/ready signals of the frame generator. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface lfsr_frame_gen_if #(
  parameter int WIDTH = 4
) ();
  logic             seed_load;
  logic [WIDTH-1:0] seed;
  logic             start;
  logic             abort;
  logic             out_ready;
  logic             out_bit;
  logic             out_valid;
  logic             busy;
  logic             done;
  logic             lockup;

  modport master (
    output seed_load, seed, start, abort, out_ready,
    input  out_bit, out_valid, busy, done, lockup
  );

  modport slave (
    input  seed_load, seed, start, abort, out_ready,
    output out_bit, out_valid, busy, done, lockup
  );
endinterface
`default_nettype wire

// File: rtl/lfsr_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lfsr_core                                                            |
// | Fibonacci LFSR state register with load (priority), step and hold.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 4,
  parameter logic [WIDTH-1:0] TAPS         = 4'b0011,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 4'b0001
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] w_next;

  assign w_next = WIDTH'(lfsr_next(32'(r_state), 32'(TAPS), WIDTH));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= DEFAULT_SEED;
    end else if (load) begin
      r_state <= load_val;
    end else if (step) begin
      r_state <= w_next;
    end
  end

  assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/lfsr_frame_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lfsr_frame_gen                                                       |
// | Seedable LFSR with warm-up run, emitting fixed-length serial frames  |
// | over valid/ready, with abort and all-zero seed protection.           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lfsr_frame_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 4,
  parameter logic [WIDTH-1:0] TAPS         = 4'b0011,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 4'b0001,
  parameter int               WARMUP       = 8,
  parameter int               FRAME_LEN    = 4
) (
  input  logic              CLK,
  input  logic              RST,
  lfsr_frame_gen_if.slave   bus
);

  localparam int c_MAX = (WARMUP > FRAME_LEN) ? WARMUP : FRAME_LEN;
  localparam int c_CW  = (c_MAX < 1) ? 1 : $clog2(c_MAX + 1);
  localparam logic [c_CW-1:0] c_WARM_LAST  = c_CW'((WARMUP == 0) ? 0 : WARMUP - 1);
  localparam logic [c_CW-1:0] c_FRAME_LAST = c_CW'(FRAME_LEN - 1);

  logic [1:0]       r_fsm;
  logic [c_CW-1:0]  r_cnt;
  logic             r_done;
  logic             r_lockup;
  logic [WIDTH-1:0] w_state;
  logic             w_idle;
  logic             w_load;
  logic             w_seed_zero;
  logic [WIDTH-1:0] w_load_val;
  logic             w_accept;
  logic             w_step;

  assign w_idle      = (r_fsm == c_ST_IDLE);
  assign w_seed_zero = (bus.seed == '0);
  assign w_load      = w_idle && bus.seed_load;
  assign w_load_val  = w_seed_zero ? DEFAULT_SEED : bus.seed;
  // abort wins over a same-cycle accept: no step, no count
  assign w_accept    = (r_fsm == c_ST_GEN) && bus.out_ready && !bus.abort;
  assign w_step      = ((r_fsm == c_ST_WARM) && !bus.abort) || w_accept;

  lfsr_core #(
    .WIDTH        (WIDTH),
    .TAPS         (TAPS),
    .DEFAULT_SEED (DEFAULT_SEED)
  ) u_core (
    .CLK      (CLK),
    .RST      (RST),
    .load     (w_load),
    .load_val (w_load_val),
    .step     (w_step),
    .state    (w_state)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_fsm    <= c_ST_IDLE;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_lockup <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_lockup <= 1'b0;
      case (r_fsm)
        c_ST_IDLE: begin
          if (bus.seed_load && w_seed_zero) begin
            r_lockup <= 1'b1;
          end
          if (bus.start) begin
            r_fsm <= (WARMUP == 0) ? c_ST_GEN : c_ST_WARM;
            r_cnt <= '0;
          end
        end
        c_ST_WARM: begin
          if (bus.abort) begin
            r_fsm <= c_ST_IDLE;
          end else if (r_cnt == c_WARM_LAST) begin
            r_fsm <= c_ST_GEN;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_ST_GEN: begin
          if (bus.abort) begin
            r_fsm <= c_ST_IDLE;
          end else if (bus.out_ready) begin
            if (r_cnt == c_FRAME_LAST) begin
              r_fsm  <= c_ST_IDLE;
              r_cnt  <= '0;
              r_done <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_fsm <= c_ST_IDLE;
      endcase
    end
  end

  assign bus.out_bit   = w_state[0];
  assign bus.out_valid = (r_fsm == c_ST_GEN);
  assign bus.busy      = !w_idle;
  assign bus.done      = r_done;
  assign bus.lockup    = r_lockup;

endmodule
`default_nettype wire
